// File: rtl/op1_host_if.sv
// op1_host_if: host register front-end for the op1 engine (result = a*b + c*d).
// The host loads operand shadows A-D, starts an operation through CTRL, and
// reads RESULT/STATUS back. Operands are frozen toward the engine for the
// whole operation, so the host may keep writing the shadows meanwhile.
// Optional feature: define OP1_TIMEOUT_EN to abort an operation that has not
// completed within TIMEOUT_CYCLES cycles of the start; the abort sets err.
`timescale 1ns/1ps

module op1_host_if #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic [2:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        done_pulse,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic [31:0] op_c,
   output logic [31:0] op_d,
   output logic        op_input_STB,
   input  logic        op_BUSY,
   input  logic [31:0] op_result,
   input  logic        op_output_STB,
   output logic        op_output_module_BUSY
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ISSUE    = 2'd1,
      S_WAIT_RES = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_a, r_b, r_c, r_d;
   logic [31:0] r_op_a, r_op_b, r_op_c, r_op_d;
   logic [31:0] r_result;
   logic        r_done;
   logic        r_done_pulse;
   logic        r_in_stb;
   logic        r_out_busy;
   logic        w_busy;
   logic        w_start;
   logic        w_in_xfer;
   logic        w_out_xfer;
   logic        w_timeout;
   logic        w_err;
   logic [31:0] w_rd_data;

   assign w_busy     = (r_state != S_IDLE);
   // A start is only honoured while idle; in any other state it is dropped.
   assign w_start    = wr_en && (wr_addr == 3'd4) && wr_data[0] && !w_busy;
   assign w_in_xfer  = r_in_stb && !op_BUSY;
   // r_out_busy is low only while waiting for a result, so this is also the capture condition.
   assign w_out_xfer = op_output_STB && !r_out_busy;

`ifdef OP1_TIMEOUT_EN
   localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_err;

   // The abort fires on the edge that would bring the count to TIMEOUT_CYCLES.
   assign w_timeout = w_busy && (r_tmo_cnt == TMO_LAST);
   assign w_err     = r_err;

   // Cycle budget of the operation in flight and the sticky error its expiry raises.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tmo_cnt <= {TMO_W{1'b0}};
         r_err     <= 1'b0;
      end else if (w_start) begin
         r_tmo_cnt <= {TMO_W{1'b0}};
         r_err     <= 1'b0;
      end else begin
         if (w_busy) begin
            r_tmo_cnt <= r_tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
         end
         // A result arriving on the expiry edge still completes the operation.
         if (w_timeout && !w_out_xfer) begin
            r_err <= 1'b1;
         end
      end
   end
`else
   // Without the timeout the parameter has no effect; err is permanently clear.
   logic w_unused_tmo_cfg;
   assign w_unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
   assign w_timeout        = 1'b0;
   assign w_err            = 1'b0;
`endif

   // Next-state selection: start, engine accept, result capture, timeout abort.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) w_next_state = S_ISSUE;
            else         w_next_state = S_IDLE;
         end
         S_ISSUE: begin
            if (w_timeout)      w_next_state = S_IDLE;
            else if (w_in_xfer) w_next_state = S_WAIT_RES;
            else                w_next_state = S_ISSUE;
         end
         S_WAIT_RES: begin
            if (w_out_xfer)     w_next_state = S_IDLE;
            else if (w_timeout) w_next_state = S_IDLE;
            else                w_next_state = S_WAIT_RES;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register and the registered handshake outputs derived from the next state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_in_stb     <= 1'b0;
         r_out_busy   <= 1'b1;
         r_done_pulse <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_in_stb     <= (w_next_state == S_ISSUE);
         r_out_busy   <= (w_next_state != S_WAIT_RES);
         r_done_pulse <= w_out_xfer;
      end
   end

   // Operand shadows, frozen engine operands, result capture and sticky done.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_c      <= 32'd0;
         r_d      <= 32'd0;
         r_op_a   <= 32'd0;
         r_op_b   <= 32'd0;
         r_op_c   <= 32'd0;
         r_op_d   <= 32'd0;
         r_result <= 32'd0;
         r_done   <= 1'b0;
      end else begin
         if (wr_en) begin
            case (wr_addr)
               3'd0:    r_a <= wr_data;
               3'd1:    r_b <= wr_data;
               3'd2:    r_c <= wr_data;
               3'd3:    r_d <= wr_data;
               default: begin end
            endcase
         end
         // The start write targets CTRL, so the copy always sees settled shadows.
         if (w_start) begin
            r_op_a <= r_a;
            r_op_b <= r_b;
            r_op_c <= r_c;
            r_op_d <= r_d;
            r_done <= 1'b0;
         end else if (w_out_xfer) begin
            r_result <= op_result;
            r_done   <= 1'b1;
         end
      end
   end

   // Host read mux; unmapped addresses read as zero.
   always_comb begin
      w_rd_data = 32'd0;
      case (rd_addr)
         3'd0:    w_rd_data = r_a;
         3'd1:    w_rd_data = r_b;
         3'd2:    w_rd_data = r_c;
         3'd3:    w_rd_data = r_d;
         3'd5:    w_rd_data = r_result;
         3'd6:    w_rd_data = {29'd0, w_err, r_done, w_busy};
         default: w_rd_data = 32'd0;
      endcase
   end

   assign rd_data               = w_rd_data;
   assign done_pulse            = r_done_pulse;
   assign op_a                  = r_op_a;
   assign op_b                  = r_op_b;
   assign op_c                  = r_op_c;
   assign op_d                  = r_op_d;
   assign op_input_STB          = r_in_stb;
   assign op_output_module_BUSY = r_out_busy;

endmodule

// File: tb/tb_op1_host_if.sv
// Bench for op1_host_if: transaction-level model of the host interface, one
// per-cycle compare process, directed scenarios with literal expectations,
// then a randomized phase against the same model.
`timescale 1ns/1ps

module tb_op1_host_if;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [31:0] wr_data;
   logic [2:0]  rd_addr;
   logic [31:0] rd_data;
   logic        done_pulse;
   logic [31:0] op_a, op_b, op_c, op_d;
   logic        op_input_STB;
   logic        op_BUSY;
   logic [31:0] op_result;
   logic        op_output_STB;
   logic        op_output_module_BUSY;

   op1_host_if #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .done_pulse(done_pulse),
      .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
      .op_input_STB(op_input_STB), .op_BUSY(op_BUSY), .op_result(op_result),
      .op_output_STB(op_output_STB), .op_output_module_BUSY(op_output_module_BUSY)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int n_pulse = 0;
   bit chk_en = 1'b0;

   // Model: an operation is "requested" until the engine takes it, then "awaited" until its result arrives.
   logic [31:0] m_sh [4];
   logic [31:0] m_op [4];
   logic [31:0] m_res;
   bit          m_done, m_err, m_pulse, m_req, m_wait;
   int          m_elapsed;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [2:0] a);
      case (a)
         3'd0, 3'd1, 3'd2, 3'd3: return m_sh[a[1:0]];
         3'd5:    return m_res;
         3'd6:    return {29'd0, m_err, m_done, (m_req || m_wait)};
         default: return 32'd0;
      endcase
   endfunction

   // Single-precision <-> real for normal numbers (engine model only).
   function automatic real sp2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'd0) return 0.0;
      d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // Apply the host-interface rules for one rising edge, using the inputs present at it.
   task automatic model_edge();
      bit busy0, in_x, out_x, start;
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin m_sh[i] = 32'd0; m_op[i] = 32'd0; end
         m_res = 32'd0; m_done = 0; m_err = 0; m_pulse = 0;
         m_req = 0; m_wait = 0; m_elapsed = 0;
         return;
      end
      busy0   = m_req || m_wait;
      in_x    = m_req && !op_BUSY;
      out_x   = m_wait && op_output_STB;
      start   = !busy0 && wr_en && (wr_addr == 3'd4) && wr_data[0];
      m_pulse = 0;
      if (out_x) begin
         m_res = op_result; m_done = 1; m_pulse = 1; m_wait = 0;
      end else if (in_x) begin
         m_req = 0; m_wait = 1;
      end
      if (start) begin
         for (int i = 0; i < 4; i++) m_op[i] = m_sh[i];
         m_done = 0; m_err = 0; m_req = 1; m_elapsed = 0;
      end
`ifdef OP1_TIMEOUT_EN
      if (busy0) begin
         m_elapsed++;
         if (m_elapsed == TMO && !out_x) begin
            m_err = 1; m_req = 0; m_wait = 0;
         end
      end
`endif
      if (wr_en && wr_addr < 3'd4) m_sh[wr_addr[1:0]] = wr_data;
   endtask

   // Compare every DUT output against the model on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("op_input_STB", {31'd0, op_input_STB}, {31'd0, m_req});
         chk("op_output_module_BUSY", {31'd0, op_output_module_BUSY}, {31'd0, !m_wait});
         chk("done_pulse", {31'd0, done_pulse}, {31'd0, m_pulse});
         chk("op_a", op_a, m_op[0]);
         chk("op_b", op_b, m_op[1]);
         chk("op_c", op_c, m_op[2]);
         chk("op_d", op_d, m_op[3]);
         chk("rd_data", rd_data, exp_rd(rd_addr));
         if (done_pulse === 1'b1) n_pulse++;
      end
   end

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
      rd_addr = a;
      #1;
      chk(nm, rd_data, exp);
   endtask

   int p0;

   initial begin
      rst = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 32'd0; rd_addr = 3'd6;
      op_BUSY = 1'b0; op_result = 32'd0; op_output_STB = 1'b0;
      tick(); tick();
      chk_en = 1'b1;
      rd_chk("reset_status", 3'd6, 32'd0);
      chk("reset_out_busy", {31'd0, op_output_module_BUSY}, 32'd1);
      chk("reset_in_stb", {31'd0, op_input_STB}, 32'd0);
      rst = 1'b1;

      // Basic operation with the engine holding BUSY for 10 cycles.
      wr(3'd0, 32'h3F800000); wr(3'd1, 32'h40000000);
      wr(3'd2, 32'h40400000); wr(3'd3, 32'h40800000);
      p0 = n_pulse;
      op_BUSY = 1'b1;
      wr(3'd4, 32'd1);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'd1; end
         else wr_en = 1'b0;
         tick();
         chk("stb_held_while_engine_busy", {31'd0, op_input_STB}, 32'd1);
      end
      wr_en = 1'b0; op_BUSY = 1'b0;
      tick();
      chk("stb_drop_after_accept", {31'd0, op_input_STB}, 32'd0);
      chk("out_busy_low_waiting", {31'd0, op_output_module_BUSY}, 32'd0);
      wr(3'd0, 32'h40A00000);
      wr(3'd4, 32'd1);
      chk("op_a_frozen", op_a, 32'h3F800000);
      rd_chk("shadow_a_updated", 3'd0, 32'h40A00000);
      rd_chk("status_busy", 3'd6, 32'd1);
      op_result = r2sp(sp2r(op_a) * sp2r(op_b) + sp2r(op_c) * sp2r(op_d));
      op_output_STB = 1'b1;
      tick();
      op_output_STB = 1'b0;
      chk("done_pulse_high", {31'd0, done_pulse}, 32'd1);
      rd_chk("result_value", 3'd5, 32'h41600000);
      rd_chk("status_done", 3'd6, 32'd2);
      repeat (5) tick();
      chk("single_done_pulse", n_pulse - p0, 32'd1);

      // Reset while waiting for the result abandons the operation.
      p0 = n_pulse;
      wr(3'd4, 32'd1);
      tick();
      chk("waiting_before_reset", {31'd0, op_output_module_BUSY}, 32'd0);
      rst = 1'b0; tick(); rst = 1'b1;
      rd_chk("status_after_reset", 3'd6, 32'd0);
      chk("out_busy_after_reset", {31'd0, op_output_module_BUSY}, 32'd1);
      op_output_STB = 1'b1; op_result = 32'hDEADBEEF;
      repeat (3) tick();
      op_output_STB = 1'b0;
      tick();
      chk("no_pulse_after_reset", n_pulse - p0, 32'd0);

      // Engine never returns a result.
      p0 = n_pulse;
      wr(3'd4, 32'd1);
`ifdef OP1_TIMEOUT_EN
      repeat (15) tick();
      rd_chk("status_before_timeout", 3'd6, 32'd1);
      tick();
      rd_chk("status_timeout", 3'd6, 32'd4);
      chk("timeout_stb", {31'd0, op_input_STB}, 32'd0);
      chk("timeout_out_busy", {31'd0, op_output_module_BUSY}, 32'd1);
      chk("no_pulse_on_timeout", n_pulse - p0, 32'd0);
`else
      repeat (40) tick();
      rd_chk("status_still_waiting", 3'd6, 32'd1);
      chk("no_pulse_while_waiting", n_pulse - p0, 32'd0);
      rst = 1'b0; tick(); rst = 1'b1;
`endif

      // Randomized traffic on both ports, checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 99) != 0);
         wr_en         = ($urandom_range(0, 1) == 1);
         wr_addr       = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
         wr_data       = $urandom;
         rd_addr       = 3'($urandom_range(0, 7));
         op_BUSY       = ($urandom_range(0, 2) == 0);
         op_output_STB = ($urandom_range(0, 3) == 0);
         op_result     = $urandom;
         tick();
      end
      rst = 1'b1; wr_en = 1'b0; op_output_STB = 1'b0; op_BUSY = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
